pwm_shadow_ctrl: RTL and testbench

PWM_SHADOW_CTRL -- requirements
Module: pwm_shadow_ctrl

---
 rtl/pwm_shadow_ctrl.sv | 125 ++++++++++++
 tb/tb_pwm_shadow_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_shadow_ctrl.sv
// Shadow/active register bank for a PWM core.
// Commits shadow values to active immediately or on carrier zero/max edges.
module pwm_shadow_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [2:0]       wr_addr,
  input  logic [CNT_W-1:0] wr_data,
  input  logic             commit_req,
  input  logic [1:0]       upd_mode,
  input  logic             pwm_on,
  input  logic [CNT_W-1:0] carrier,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] init_carr_o,
  output logic [CNT_W-1:0] compare_1_o,
  output logic [CNT_W-1:0] compare_2_o,
  output logic [CNT_W-1:0] compare_3_o,
  output logic [CNT_W-1:0] compare_4_o,
  output logic [CNT_W-1:0] dtime_A_o,
  output logic [CNT_W-1:0] dtime_B_o,
  output logic             busy,
  output logic             commit_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_APPLY
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_carr_q;
  logic             r_done;
  logic [CNT_W-1:0] r_shadow [8];
  logic [CNT_W-1:0] r_act    [8];

  logic w_idle;
  logic w_wr_fire;
  logic w_zero_evt;
  logic w_max_evt;
  logic w_sel_evt;

  assign w_idle    = (r_state == S_IDLE);
  assign w_wr_fire = wr_valid && w_idle;

  // Edge-qualified: a carrier parked on 0 or max yields one event.
  assign w_zero_evt = (carrier == '0) && (r_carr_q != '0);
  assign w_max_evt  = (carrier == r_act[0]) &&
                      (r_carr_q != r_act[0]);

  always_comb begin
    w_sel_evt = 1'b0;
    unique case (r_mode)
      2'b00: w_sel_evt = 1'b1;
      2'b01: w_sel_evt = w_zero_evt;
      2'b10: w_sel_evt = w_max_evt;
      2'b11: w_sel_evt = w_zero_evt || w_max_evt;
      default: w_sel_evt = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (commit_req) begin
          if (upd_mode == 2'b00 || !pwm_on)
            w_next = S_APPLY;
          else
            w_next = S_ARMED;
        end
      end
      S_ARMED: begin
        if (!pwm_on || w_sel_evt)
          w_next = S_APPLY;
      end
      S_APPLY: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_mode   <= 2'b00;
      r_carr_q <= '0;
      r_done   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_shadow[i] <= '0;
        r_act[i]    <= '0;
      end
    end else begin
      r_state  <= w_next;
      r_carr_q <= carrier;
      r_done   <= (r_state == S_APPLY);
      if (w_wr_fire)
        r_shadow[wr_addr] <= wr_data;
      if (w_idle && commit_req)
        r_mode <= upd_mode;
      if (r_state == S_APPLY) begin
        for (int i = 0; i < 8; i++)
          r_act[i] <= r_shadow[i];
      end
    end
  end

  assign wr_ready    = w_idle;
  assign busy        = !w_idle;
  assign commit_done = r_done;

  assign period_o    = r_act[0];
  assign init_carr_o = r_act[1];
  assign compare_1_o = r_act[2];
  assign compare_2_o = r_act[3];
  assign compare_3_o = r_act[4];
  assign compare_4_o = r_act[5];
  assign dtime_A_o   = r_act[6];
  assign dtime_B_o   = r_act[7];

endmodule

// File: tb/tb_pwm_shadow_ctrl.sv
// Bench for pwm_shadow_ctrl: directed scenarios plus random traffic
// checked every cycle against a cycle-stamped commit model.
module tb_pwm_shadow_ctrl;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, wr_valid, commit_req, pwm_on;
  logic [2:0]   wr_addr;
  logic [1:0]   upd_mode;
  logic [W-1:0] wr_data, carrier;
  logic         wr_ready, busy, commit_done;
  logic [W-1:0] period_o, init_carr_o;
  logic [W-1:0] compare_1_o, compare_2_o, compare_3_o, compare_4_o;
  logic [W-1:0] dtime_A_o, dtime_B_o;

  pwm_shadow_ctrl #(.CNT_W(W)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .commit_req(commit_req), .upd_mode(upd_mode),
    .pwm_on(pwm_on), .carrier(carrier),
    .period_o(period_o), .init_carr_o(init_carr_o),
    .compare_1_o(compare_1_o), .compare_2_o(compare_2_o),
    .compare_3_o(compare_3_o), .compare_4_o(compare_4_o),
    .dtime_A_o(dtime_A_o), .dtime_B_o(dtime_B_o),
    .busy(busy), .commit_done(commit_done)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc_n = 0;
  int pulses = 0;

  // Model: shadow/active arrays, a pending wait flag and the cycle
  // number on which commit_done must be seen.
  logic [W-1:0] m_sh  [8];
  logic [W-1:0] m_act [8];
  logic [W-1:0] m_cq;
  bit           m_wait;
  logic [1:0]   m_mode;
  int           m_done_at;

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               nm, act, exp, cyc_n);
    end
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b at cycle %0d",
               nm, act, exp, cyc_n);
    end
  endtask

  function automatic logic [W-1:0] dut_act(int i);
    case (i)
      0: return period_o;
      1: return init_carr_o;
      2: return compare_1_o;
      3: return compare_2_o;
      4: return compare_3_o;
      5: return compare_4_o;
      6: return dtime_A_o;
      default: return dtime_B_o;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_sh[i]  = '0;
      m_act[i] = '0;
    end
    m_cq      = '0;
    m_wait    = 0;
    m_mode    = 2'b00;
    m_done_at = -1;
  endtask

  // One clock: compare every output, advance model, cross the edge.
  task automatic tick();
    bit m_busy, z_e, x_e, fire;
    m_busy = m_wait || (m_done_at > cyc_n);
    chk1("busy", busy, m_busy);
    chk1("wr_ready", wr_ready, !m_busy);
    chk1("commit_done", commit_done, m_done_at == cyc_n);
    for (int i = 0; i < 8; i++)
      chk($sformatf("active%0d", i), dut_act(i), m_act[i]);
    if (commit_done) pulses++;

    if (reset) begin
      model_reset();
    end else begin
      z_e = (carrier == 0) && (m_cq != 0);
      x_e = (carrier == m_act[0]) && (m_cq != m_act[0]);
      if (m_done_at == cyc_n + 1)
        for (int i = 0; i < 8; i++) m_act[i] = m_sh[i];
      if (!m_busy) begin
        if (wr_valid) m_sh[wr_addr] = wr_data;
        if (commit_req) begin
          if (upd_mode == 2'b00 || !pwm_on) m_done_at = cyc_n + 2;
          else begin
            m_wait = 1;
            m_mode = upd_mode;
          end
        end
      end else if (m_wait) begin
        fire = !pwm_on ||
               (m_mode == 2'b01 && z_e) ||
               (m_mode == 2'b10 && x_e) ||
               (m_mode == 2'b11 && (z_e || x_e));
        if (fire) begin
          m_wait = 0;
          m_done_at = cyc_n + 2;
        end
      end
      m_cq = carrier;
    end
    @(posedge clk);
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic wr(logic [2:0] a, logic [W-1:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic commit(logic [1:0] md);
    commit_req = 1'b1;
    upd_mode   = md;
    tick();
    commit_req = 1'b0;
  endtask

  task automatic cyc(logic [W-1:0] c);
    carrier = c;
    tick();
  endtask

  int tc, dcnt, dv, pk;
  bit up;

  initial begin
    reset = 1'b1; wr_valid = 1'b0; commit_req = 1'b0;
    pwm_on = 1'b1; wr_addr = '0; upd_mode = '0;
    wr_data = '0; carrier = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    reset = 1'b0;

    // Reset state
    chk("rst_period", period_o, 16'd0);
    chk1("rst_wr_ready", wr_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", commit_done, 1'b0);

    // Immediate commit
    wr(3'd0, 16'd2000);
    wr(3'd2, 16'd1000);
    chk("shadow_only", period_o, 16'd0);
    commit(2'b00);
    chk1("imm_busy", busy, 1'b1);
    tick();
    chk1("imm_done", commit_done, 1'b1);
    chk("imm_period", period_o, 16'd2000);
    chk("imm_cmp1", compare_1_o, 16'd1000);

    // Zero-aligned commit, carrier parked at 0 for two clocks
    wr(3'd2, 16'd667);
    cyc(16'd500);
    pulses = 0;
    carrier = 16'd500;
    commit(2'b01);
    cyc(16'd1000); cyc(16'd1500); cyc(16'd2000); cyc(16'd2000);
    cyc(16'd1500); cyc(16'd1000); cyc(16'd500);
    carrier = 16'd0;
    chk("zero_hold0", compare_1_o, 16'd1000);
    tick();
    chk("zero_hold1", compare_1_o, 16'd1000);
    chk1("zero_busy", busy, 1'b1);
    tick();
    carrier = 16'd500;
    chk1("zero_done", commit_done, 1'b1);
    chk("zero_cmp1", compare_1_o, 16'd667);
    tick();
    cyc(16'd1000);
    chk("zero_pulses", 16'(pulses), 16'd1);

    // Max-aligned commit against the old period
    wr(3'd0, 16'd1500);
    commit(2'b10);
    carrier = 16'd1500;
    chk1("max_busy", busy, 1'b1);
    tick();
    cyc(16'd2000);
    cyc(16'd1800);
    carrier = 16'd1500;
    chk1("max_done", commit_done, 1'b1);
    chk("max_period", period_o, 16'd1500);
    tick();

    // Stall: held write during ARMED lands in shadow only
    wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 16'd111;
    commit(2'b01);
    wr_addr = 3'd4; wr_data = 16'd4242;
    carrier = 16'd1000;
    chk1("stall_ready", wr_ready, 1'b0);
    tick();
    cyc(16'd500);
    cyc(16'd0);
    carrier = 16'd0;
    chk1("stall_apply", wr_ready, 1'b0);
    tick();
    carrier = 16'd100;
    chk1("stall_done", commit_done, 1'b1);
    chk1("stall_ready2", wr_ready, 1'b1);
    chk("stall_cmp2", compare_2_o, 16'd111);
    tick();
    wr_valid = 1'b0;
    chk("stall_cmp3", compare_3_o, 16'd0);
    commit(2'b00);
    tick();
    chk("stall_cmp3b", compare_3_o, 16'd4242);
    tick();

    // Frozen carrier
    commit(2'b01);
    pwm_on = 1'b0;
    tick();
    chk1("frz_busy", busy, 1'b1);
    tick();
    chk1("frz_done", commit_done, 1'b1);
    tick();
    pwm_on = 1'b1;

    // Reset while armed
    commit(2'b01);
    chk1("ra_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("ra_busy0", busy, 1'b0);
    chk("ra_period", period_o, 16'd0);
    chk("ra_cmp3", compare_3_o, 16'd0);
    chk1("ra_done", commit_done, 1'b0);
    cyc(16'd0); cyc(16'd0);
    chk1("ra_done2", commit_done, 1'b0);

    // Period 0 with mode 11
    cyc(16'd5);
    commit(2'b11);
    cyc(16'd0);
    tick();
    chk1("p0_done", commit_done, 1'b1);
    tick();
    wr(3'd0, 16'd10);
    commit(2'b00);
    tick();
    chk("p10_period", period_o, 16'd10);

    // Random traffic
    tc = 0; up = 1; dcnt = 0; dv = 1;
    for (int n = 0; n < 4000; n++) begin
      pk = int'(m_act[0]);
      if (dcnt == 0) begin
        dcnt = dv;
        if ($urandom_range(0, 15) == 0) dv = $urandom_range(0, 2);
        if (pk == 0) tc = 0;
        else if (tc > pk) begin tc = pk; up = 0; end
        else if (up) begin
          if (tc >= pk) begin up = 0; tc = pk - 1; end
          else tc++;
        end else begin
          if (tc == 0) begin up = 1; tc = 1; end
          else tc--;
        end
      end else dcnt--;
      carrier    = tc[W-1:0];
      reset      = ($urandom_range(0, 199) == 0);
      pwm_on     = ($urandom_range(0, 24) != 0);
      wr_valid   = ($urandom_range(0, 9) < 4);
      wr_addr    = 3'($urandom);
      wr_data    = (wr_addr == 3'd0) ? W'($urandom_range(0, 12))
                                     : W'($urandom);
      commit_req = ($urandom_range(0, 9) == 0);
      upd_mode   = 2'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
